id_stage: RTL and testbench



---
 rtl/id_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage -- registered instruction-decode stage for the MIPS-subset core.
//
// Decodes one 32-bit instruction per accepted valid/ready handshake into the
// control bundle used by execute, and holds it in an output register.
//
// A write-pending scoreboard of SB_DEPTH entries tracks destinations in flight.
// Issue stalls on RAW, WAW or a full scoreboard until writeback retires the
// pending destination. Hazards are judged on the registered scoreboard only,
// so a retire releases a stall one cycle later.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    fetch handshake (in_ready is combinational on inst)
//   inst[31:0]           instruction word
//   out_valid/out_ready  execute handshake
//   wen..invalid         registered decode bundle
//   wb_valid, wb_addr    writeback retire of a pending destination
//   sb_count             number of pending writes
module id_stage #(
  parameter int SB_DEPTH    = 4,
  parameter int ALU_CW      = 5,
  parameter bit SUPPRESS_R0 = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   inst,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          wen,
  output logic [4:0]                    waddr,
  output logic                          rden1,
  output logic [4:0]                    raddr1,
  output logic                          rden2,
  output logic [4:0]                    raddr2,
  output logic                          alu_en,
  output logic [ALU_CW-1:0]             alu_card,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic                          jmp,
  output logic                          invalid,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_addr,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count
);

  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  localparam logic [ALU_CW-1:0] ALU_ADD = ALU_CW'(1);
  localparam logic [ALU_CW-1:0] ALU_SUB = ALU_CW'(2);
  localparam logic [ALU_CW-1:0] ALU_AND = ALU_CW'(3);
  localparam logic [ALU_CW-1:0] ALU_OR  = ALU_CW'(4);
  localparam logic [ALU_CW-1:0] ALU_XOR = ALU_CW'(5);
  localparam logic [ALU_CW-1:0] ALU_NOR = ALU_CW'(6);
  localparam logic [ALU_CW-1:0] ALU_SLT = ALU_CW'(7);

  typedef struct packed {
    logic              wen;
    logic [4:0]        waddr;
    logic              rden1;
    logic [4:0]        raddr1;
    logic              rden2;
    logic [4:0]        raddr2;
    logic              alu_en;
    logic [ALU_CW-1:0] alu_card;
    logic              mem_rd;
    logic              mem_wr;
    logic              jmp;
    logic              invalid;
  } ctl_t;

  function automatic ctl_t decode(input logic [31:0] iw);
    ctl_t              c;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic              funct_ok;
    logic [ALU_CW-1:0] card;
    op       = iw[31:26];
    rs       = iw[25:21];
    rt       = iw[20:16];
    rd       = iw[15:11];
    funct    = iw[5:0];
    c        = '0;
    funct_ok = 1'b1;
    card     = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20:   card = ALU_ADD;
          6'h22:   card = ALU_SUB;
          6'h24:   card = ALU_AND;
          6'h25:   card = ALU_OR;
          6'h26:   card = ALU_XOR;
          6'h27:   card = ALU_NOR;
          6'h2A:   card = ALU_SLT;
          default: funct_ok = 1'b0;
        endcase
        if (funct_ok) begin
          c.rden1    = 1'b1;
          c.raddr1   = rs;
          c.rden2    = 1'b1;
          c.raddr2   = rt;
          c.wen      = 1'b1;
          c.waddr    = rd;
          c.alu_en   = 1'b1;
          c.alu_card = card;
        end else begin
          c.invalid = 1'b1;
        end
      end
      6'h23: begin
        c.rden1    = 1'b1;
        c.raddr1   = rs;
        c.wen      = 1'b1;
        c.waddr    = rt;
        c.alu_en   = 1'b1;
        c.alu_card = ALU_ADD;
        c.mem_rd   = 1'b1;
      end
      6'h2B: begin
        c.rden1    = 1'b1;
        c.raddr1   = rs;
        c.rden2    = 1'b1;
        c.raddr2   = rt;
        c.alu_en   = 1'b1;
        c.alu_card = ALU_ADD;
        c.mem_wr   = 1'b1;
      end
      6'h02:   c.jmp = 1'b1;
      default: c.invalid = 1'b1;
    endcase
    // r0 is hardwired; a write to it carries no dependency worth tracking.
    if (SUPPRESS_R0 && c.wen && (c.waddr == 5'd0)) begin
      c.wen = 1'b0;
    end
    return c;
  endfunction

  ctl_t                dec_p0;
  ctl_t                bundle_p1;
  logic                vld_p1;
  logic [SB_DEPTH-1:0] sb_vld;
  logic [4:0]          sb_addr [SB_DEPTH];
  logic [SB_DEPTH-1:0] alloc_oh;
  logic [SB_DEPTH-1:0] ret_oh;
  logic [CNT_W-1:0]    cnt;
  logic                hit_r1;
  logic                hit_r2;
  logic                hit_w;
  logic                found;
  logic                full;
  logic                hazard;
  logic                accept;
  logic                unused_inst_bits;

  assign unused_inst_bits = ^inst[10:6];

  // ---- stage p0: combinational decode and hazard check ----
  assign dec_p0 = decode(inst);

  always_comb begin
    hit_r1   = 1'b0;
    hit_r2   = 1'b0;
    hit_w    = 1'b0;
    cnt      = '0;
    alloc_oh = '0;
    ret_oh   = '0;
    found    = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      cnt = cnt + CNT_W'(sb_vld[i]);
      if (sb_vld[i] && (sb_addr[i] == dec_p0.raddr1)) hit_r1 = 1'b1;
      if (sb_vld[i] && (sb_addr[i] == dec_p0.raddr2)) hit_r2 = 1'b1;
      if (sb_vld[i] && (sb_addr[i] == dec_p0.waddr))  hit_w  = 1'b1;
      if (wb_valid && sb_vld[i] && (sb_addr[i] == wb_addr)) ret_oh[i] = 1'b1;
      if (!sb_vld[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Full uses the pre-retire count, so a retire cannot free a slot for an
  // allocate in the same cycle.
  assign full   = dec_p0.wen && (cnt == CNT_W'(SB_DEPTH));
  assign hazard = (dec_p0.rden1 && hit_r1) || (dec_p0.rden2 && hit_r2) ||
                  (dec_p0.wen && hit_w) || full;

  assign in_ready = rst_n && (!vld_p1 || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign sb_count = cnt;

  // ---- stage p1: output register and scoreboard state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      bundle_p1 <= dec_p0;
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  // An allocated slot is always free and a retired slot always valid, so the
  // two one-hot vectors never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld <= '0;
    end else begin
      sb_vld <= (sb_vld & ~ret_oh) | ((accept && dec_p0.wen) ? alloc_oh : '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (accept && dec_p0.wen && alloc_oh[i]) sb_addr[i] <= dec_p0.waddr;
    end
  end

  assign out_valid = vld_p1;
  assign wen       = bundle_p1.wen;
  assign waddr     = bundle_p1.waddr;
  assign rden1     = bundle_p1.rden1;
  assign raddr1    = bundle_p1.raddr1;
  assign rden2     = bundle_p1.rden2;
  assign raddr2    = bundle_p1.raddr2;
  assign alu_en    = bundle_p1.alu_en;
  assign alu_card  = bundle_p1.alu_card;
  assign mem_rd    = bundle_p1.mem_rd;
  assign mem_wr    = bundle_p1.mem_wr;
  assign jmp       = bundle_p1.jmp;
  assign invalid   = bundle_p1.invalid;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: decode table plus hazard, backpressure and reset sequences.
module tb_id_stage;

  localparam int SB_DEPTH = 4;
  localparam int ALU_CW   = 5;
  localparam int NV       = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        wen, rden1, rden2, alu_en, mem_rd, mem_wr, jmp, invalid;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [ALU_CW-1:0] alu_card;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [2:0]  sb_count;

  typedef struct packed {
    logic       wen;
    logic [4:0] waddr;
    logic       rden1;
    logic [4:0] raddr1;
    logic       rden2;
    logic [4:0] raddr2;
    logic       alu_en;
    logic [4:0] alu_card;
    logic       mem_rd;
    logic       mem_wr;
    logic       jmp;
    logic       invalid;
  } bundle_t;

  typedef struct {
    logic [31:0] inst;
    bundle_t     exp;
  } vec_t;

  bundle_t got;
  vec_t    vecs [NV];
  int      total = 0;
  int      bad = 0;

  assign got = {wen, waddr, rden1, raddr1, rden2, raddr2, alu_en, alu_card,
                mem_rd, mem_wr, jmp, invalid};

  id_stage #(.SB_DEPTH(SB_DEPTH), .ALU_CW(ALU_CW), .SUPPRESS_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready),
    .wen(wen), .waddr(waddr), .rden1(rden1), .raddr1(raddr1),
    .rden2(rden2), .raddr2(raddr2), .alu_en(alu_en), .alu_card(alu_card),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .jmp(jmp), .invalid(invalid),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
    tick();
    wb_valid = 1'b0;
  endtask

  function automatic bundle_t mk(input logic w, input logic [4:0] wa,
                                 input logic r1, input logic [4:0] a1,
                                 input logic r2, input logic [4:0] a2,
                                 input logic ae, input logic [4:0] card,
                                 input logic mr, input logic mw,
                                 input logic j, input logic inv);
    mk = {w, wa, r1, a1, r2, a2, ae, card, mr, mw, j, inv};
  endfunction

  initial begin
    vecs[0]  = '{32'h00430820, mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0)};    // add $1,$2,$3
    vecs[1]  = '{32'h00C72822, mk(1, 5, 1, 6, 1, 7, 1, 2, 0, 0, 0, 0)};    // sub $5,$6,$7
    vecs[2]  = '{32'h012A4024, mk(1, 8, 1, 9, 1, 10, 1, 3, 0, 0, 0, 0)};   // and $8,$9,$10
    vecs[3]  = '{32'h018D5825, mk(1, 11, 1, 12, 1, 13, 1, 4, 0, 0, 0, 0)}; // or
    vecs[4]  = '{32'h01F07026, mk(1, 14, 1, 15, 1, 16, 1, 5, 0, 0, 0, 0)}; // xor
    vecs[5]  = '{32'h02538827, mk(1, 17, 1, 18, 1, 19, 1, 6, 0, 0, 0, 0)}; // nor
    vecs[6]  = '{32'h02B6A02A, mk(1, 20, 1, 21, 1, 22, 1, 7, 0, 0, 0, 0)}; // slt
    vecs[7]  = '{32'h8CC40018, mk(1, 4, 1, 6, 0, 0, 1, 1, 1, 0, 0, 0)};    // lw $4,24($6)
    vecs[8]  = '{32'hAD270008, mk(0, 0, 1, 9, 1, 7, 1, 1, 0, 1, 0, 0)};    // sw $7,8($9)
    vecs[9]  = '{32'h08000010, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};    // j
    vecs[10] = '{32'h12345678, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};    // unknown opcode
    vecs[11] = '{32'h00430821, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};    // bad funct
    vecs[12] = '{32'h00220020, mk(0, 0, 1, 1, 1, 2, 1, 1, 0, 0, 0, 0)};    // add $0,$1,$2

    // Reset state while an instruction is offered.
    in_valid = 1'b1;
    inst     = 32'h00430820;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sb_count", sb_count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_bundle", got, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();

    // Decode table, one instruction at a time with its write retired.
    for (int k = 0; k < NV; k++) begin
      inst     = vecs[k].inst;
      in_valid = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", k), in_ready, 1);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_bundle", k), got, vecs[k].exp);
      check($sformatf("v%0d_out_valid", k), out_valid, 1);
      check($sformatf("v%0d_sb_count", k), sb_count, {2'b0, vecs[k].exp.wen});
      if (vecs[k].exp.wen) retire(vecs[k].exp.waddr);
      else tick();
      check($sformatf("v%0d_sb_empty", k), sb_count, 0);
    end

    // RAW: lw $4 then add $2,$4,$4.
    inst     = 32'h8CC40018;
    in_valid = 1'b1;
    tick();
    inst = 32'h00841020;
    #1;
    check("raw_stall0", in_ready, 0);
    tick();
    check("raw_stall1", in_ready, 0);
    wb_valid = 1'b1;
    wb_addr  = 5'd4;
    #1;
    check("raw_stall_wb_cycle", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("raw_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("raw_waddr", waddr, 2);
    check("raw_raddr1", raddr1, 4);
    check("raw_sb_count", sb_count, 1);
    retire(5'd2);

    // Full scoreboard: r1..r4 pending, r5 stalls until a retire lands.
    in_valid = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      inst = (32'(r) << 11) | 32'h20;
      #1;
      check($sformatf("fill%0d_in_ready", r), in_ready, 1);
      tick();
    end
    inst = 32'h00002820;
    #1;
    check("full_count", sb_count, 4);
    check("full_stall0", in_ready, 0);
    tick();
    check("full_stall1", in_ready, 0);
    wb_valid = 1'b1;
    wb_addr  = 5'd2;
    #1;
    check("full_stall_wb_cycle", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("full_after_wb_count", sb_count, 3);
    check("full_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("full_accept_count", sb_count, 4);
    check("full_accept_waddr", waddr, 5);
    retire(5'd1);
    retire(5'd3);
    retire(5'd4);
    retire(5'd5);
    check("full_drained", sb_count, 0);

    // Backpressure: bundle held for 3 cycles, then next accepted on release.
    out_ready = 1'b0;
    inst      = 32'h00430820;
    in_valid  = 1'b1;
    tick();
    inst = 32'h00003020;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d_in_ready", c), in_ready, 0);
      check($sformatf("hold%0d_out_valid", c), out_valid, 1);
      check($sformatf("hold%0d_waddr", c), waddr, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("hold_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("hold_next_waddr", waddr, 6);
    check("hold_next_out_valid", out_valid, 1);
    check("hold_sb_count", sb_count, 2);
    retire(5'd1);
    retire(5'd6);
    check("hold_drained", sb_count, 0);

    // Reset mid-operation with two writes pending.
    in_valid = 1'b1;
    inst     = 32'h00000820;
    tick();
    inst = 32'h00001020;
    tick();
    in_valid = 1'b0;
    check("pre_rst_count", sb_count, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_count", sb_count, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_bundle", got, 0);
    tick();
    rst_n = 1'b1;
    retire(5'd1);
    check("stale_wb_count", sb_count, 0);
    inst     = 32'h00000820;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_count", sb_count, 1);
    check("post_rst_waddr", waddr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
